// File: rtl/spu_sm_sum_ctrl.sv
// spu_sm_sum_ctrl: sequences buffer reads into the accumulating adder tree
// and returns the captured job sum through a valid/ready result port.
module spu_sm_sum_ctrl (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  len_beats,
    input  logic [11:0] base_addr,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    output logic        tree_en,
    input  logic [19:0] tree_sum,
    output logic        busy,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [19:0] sum_out,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, CAPTURE, RESULT} state_t;

    state_t      state_q;
    logic [9:0]  cnt_q;
    logic        rd_en_q;
    logic        tree_en_q;
    logic [11:0] rd_addr_q;
    logic [19:0] sum_q;
    logic        err_q;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            tree_en_q <= 1'b0;
            rd_addr_q <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            // tree sees read data one cycle after the strobe
            tree_en_q <= rd_en_q;
            case (state_q)
                IDLE: if (start) begin
                    if (len_beats == 10'd0 || len_beats > 10'd513) begin
                        state_q <= RESULT;
                        sum_q   <= '0;
                        err_q   <= (len_beats != 10'd0);
                    end else begin
                        state_q   <= READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= base_addr;
                        cnt_q     <= len_beats - 10'd1;
                    end
                end
                READ: if (cnt_q == 10'd0) begin
                    rd_en_q <= 1'b0;
                    state_q <= DRAIN;
                end else begin
                    rd_addr_q <= rd_addr_q + 12'd1;
                    cnt_q     <= cnt_q - 10'd1;
                end
                DRAIN: state_q <= CAPTURE;
                CAPTURE: begin
                    sum_q   <= tree_sum;
                    err_q   <= 1'b0;
                    state_q <= RESULT;
                end
                RESULT: if (sum_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign tree_en   = tree_en_q;
    assign busy      = (state_q != IDLE);
    assign sum_valid = (state_q == RESULT);
    assign sum_out   = sum_q;
    assign err       = err_q;
endmodule

// File: tb/tb_spu_sm_sum_ctrl.sv
// tb_spu_sm_sum_ctrl: directed bench with a registered-read buffer and
// accumulating tree model whose beats are eight copies of byte_val.
module tb_spu_sm_sum_ctrl;
    logic        core_clk = 1'b0;
    logic        rst_n, start, sum_ready;
    logic [9:0]  len_beats;
    logic [11:0] base_addr;
    logic        rd_en, tree_en, busy, sum_valid, err;
    logic [11:0] rd_addr;
    logic [19:0] tree_sum, sum_out;
    logic [7:0]  byte_val;
    logic [11:0] rdata_q = '0;
    logic [19:0] acc_q = '0;
    int total = 0;
    int passed = 0;

    always #5 core_clk = ~core_clk;

    spu_sm_sum_ctrl dut (
        .core_clk(core_clk), .rst_n(rst_n), .start(start), .len_beats(len_beats),
        .base_addr(base_addr), .rd_en(rd_en), .rd_addr(rd_addr), .tree_en(tree_en),
        .tree_sum(tree_sum), .busy(busy), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_out(sum_out), .err(err)
    );

    always @(posedge core_clk) begin
        rdata_q <= rd_en ? 12'(byte_val) * 12'd8 : 12'd0;
        acc_q   <= tree_en ? acc_q + 20'(rdata_q) : 20'd0;
    end
    assign tree_sum = acc_q;

    // Starts a job in the current cycle; returns one cycle after the result handshake.
    task automatic run_job(input string name, input int len, input logic [11:0] base,
                           input logic [7:0] bval, input int hold);
        int c, nrd, ntr, frd, ftr, vcyc, exp_vcyc;
        logic addr_bad, exp_err;
        logic [19:0] exp_sum;
        exp_err  = (len > 513);
        exp_sum  = (len >= 1 && len <= 513) ? 20'(len * 8 * int'(bval)) : 20'd0;
        exp_vcyc = (len >= 1 && len <= 513) ? len + 3 : 1;
        byte_val = bval;
        len_beats = 10'(len);
        base_addr = base;
        start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        c = 1; nrd = 0; ntr = 0; frd = 0; ftr = 0; vcyc = 0; addr_bad = 1'b0;
        while (c <= len + 10) begin
            if (sum_valid) begin
                vcyc = c;
                break;
            end
            if (rd_en) begin
                if (rd_addr !== 12'(int'(base) + nrd)) addr_bad = 1'b1;
                if (frd == 0) frd = c;
                nrd++;
            end
            if (tree_en) begin
                if (ftr == 0) ftr = c;
                ntr++;
            end
            @(posedge core_clk); #1;
            c++;
        end
        total++;
        if (vcyc !== exp_vcyc) $display("FAIL %s latency: got cycle %0d, want %0d", name, vcyc, exp_vcyc);
        else passed++;
        total++;
        if (nrd !== ((len >= 1 && len <= 513) ? len : 0) || addr_bad)
            $display("FAIL %s reads: got %0d (addr_bad=%0b), want %0d", name, nrd, addr_bad, (len <= 513) ? len : 0);
        else passed++;
        total++;
        if (ntr !== nrd || (nrd > 0 && (frd !== 1 || ftr !== 2)))
            $display("FAIL %s timing: tree_en %0d beats first %0d, rd first %0d", name, ntr, ftr, frd);
        else passed++;
        total++;
        if ({sum_out, err, busy} !== {exp_sum, exp_err, 1'b1})
            $display("FAIL %s result: got sum=%0d err=%0b busy=%0b, want sum=%0d err=%0b busy=1",
                     name, sum_out, err, busy, exp_sum, exp_err);
        else passed++;
        for (int h = 0; h < hold; h++) begin
            total++;
            if ({sum_valid, sum_out, err, rd_en} !== {1'b1, exp_sum, exp_err, 1'b0})
                $display("FAIL %s hold%0d: got valid=%0b sum=%0d err=%0b rd_en=%0b", name, h, sum_valid, sum_out, err, rd_en);
            else passed++;
            start = (h == 1);
            @(posedge core_clk); #1;
            start = 1'b0;
        end
        sum_ready = 1'b1;
        @(posedge core_clk); #1;
        sum_ready = 1'b0;
        total++;
        if ({sum_valid, busy, rd_en, tree_en} !== 4'b0)
            $display("FAIL %s release: got valid=%0b busy=%0b rd_en=%0b tree_en=%0b", name, sum_valid, busy, rd_en, tree_en);
        else passed++;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({rd_en, rd_addr, tree_en, busy, sum_valid, sum_out, err} !== 36'd0)
            $display("FAIL reset_state: got rd_en=%0b rd_addr=%h tree_en=%0b busy=%0b valid=%0b sum=%0d err=%0b",
                     rd_en, rd_addr, tree_en, busy, sum_valid, sum_out, err);
        else passed++;
        @(negedge core_clk) rst_n = 1'b1;
        @(posedge core_clk); #1;
    endtask

    task automatic test_basic;
        run_job("basic", 4, 12'h010, 8'd1, 0);
    endtask

    task automatic test_max_len;
        run_job("max_len", 513, 12'h200, 8'hFF, 0);
    endtask

    task automatic test_wrap;
        run_job("wrap", 3, 12'hFFE, 8'd7, 0);
    endtask

    task automatic test_illegal_len;
        run_job("zero_len", 0, 12'h123, 8'd9, 0);
        run_job("over_len", 600, 12'h456, 8'd9, 0);
    endtask

    task automatic test_back_to_back;
        run_job("hold_job", 4, 12'h040, 8'd2, 5);
        run_job("b2b_job", 3, 12'h050, 8'd3, 0);
    endtask

    task automatic test_reset_mid_read;
        logic was_reading;
        byte_val = 8'd1;
        len_beats = 10'd10;
        base_addr = 12'h100;
        start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        @(posedge core_clk); #1;
        was_reading = rd_en;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (!was_reading || {rd_en, rd_addr, tree_en, busy, sum_valid, sum_out, err} !== 36'd0)
            $display("FAIL mid_read_reset: reading=%0b rd_en=%0b rd_addr=%h tree_en=%0b busy=%0b valid=%0b",
                     was_reading, rd_en, rd_addr, tree_en, busy, sum_valid);
        else passed++;
        @(posedge core_clk);
        @(negedge core_clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge core_clk); #1;
            total++;
            if ({sum_valid, rd_en, busy} !== 3'b0)
                $display("FAIL post_reset_idle%0d: got valid=%0b rd_en=%0b busy=%0b", i, sum_valid, rd_en, busy);
            else passed++;
        end
        run_job("after_reset", 2, 12'h020, 8'd5, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sum_ready = 1'b0;
        len_beats = '0;
        base_addr = '0;
        byte_val = '0;
        test_reset;
        test_basic;
        test_max_len;
        test_wrap;
        test_illegal_len;
        test_back_to_back;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spu_sm_sum_ctrl.md
SPU_SM_SUM_CTRL -- requirements
Module: spu_sm_sum_ctrl

Interface
REQ-001 SHALL have core_clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have start  in  1  single-cycle job request; sampled only in IDLE.
REQ-004 SHALL have len_beats  in  10  job length in 8-byte beats; legal range 0..513.
REQ-005 SHALL have base_addr  in  12  first buffer address of the job.
REQ-006 SHALL have rd_en  out  1  buffer read strobe; read data valid at tree inputs the next cycle.
REQ-007 SHALL have rd_addr  out  12  buffer read address.
REQ-008 SHALL have tree_en  out  1  enable to the 8-input accumulating adder tree.
REQ-009 SHALL have tree_sum  in  20  running accumulator value from the adder tree.
REQ-010 SHALL have busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have sum_valid  out  1  result available.
REQ-012 SHALL have sum_ready  in  1  result consumer ready.
REQ-013 SHALL have sum_out  out  20  captured job sum.
REQ-014 SHALL have err  out  1  qualifies sum_out: job rejected for length.

Function
REQ-015 SHALL implement FSM states IDLE, READ, DRAIN, CAPTURE, RESULT.
REQ-016 SHALL go IDLE->READ on start with 1<=len_beats<=513, and latch len_beats and base_addr at that edge.
REQ-017 SHALL go IDLE->RESULT on start with len_beats==0, with sum_out=0 and err=0, and issue no reads.
REQ-018 SHALL go IDLE->RESULT on start with len_beats>513, with sum_out=0 and err=1 (accumulator overflow guard: 513*8*255 < 2^20), and issue no reads.
REQ-019 SHALL, in READ, assert rd_en for exactly len cycles with rd_addr=base_addr+k for k=0..len-1, computed modulo 4096 (wraps 4095->0).
REQ-020 SHALL go READ->DRAIN after the last read cycle.
REQ-021 SHALL drive tree_en as rd_en delayed by one register stage, so it is high for exactly len consecutive cycles.
REQ-022 SHALL spend one cycle in DRAIN, during which the final tree_en beat is accumulated, then go to CAPTURE.
REQ-023 SHALL, in CAPTURE, register tree_sum into sum_out with err=0 and go to RESULT; tree_en is low in this cycle, so the tree self-clears at the next edge.
REQ-024 SHALL hold sum_valid high in RESULT with sum_out and err stable until the cycle in which sum_ready=1, then go to IDLE.
REQ-025 SHALL make start-to-sum_valid latency len+3 cycles for a legal job with len>=1: start sampled at edge 0, reads in cycles 1..len, sum_valid from cycle len+3.
REQ-026 SHALL ignore start outside IDLE; there is no queueing.
REQ-027 SHALL accept start in the cycle immediately after the RESULT handshake; tree_en is guaranteed low for at least two cycles between jobs.
REQ-028 SHALL keep rd_en and tree_en low in IDLE and RESULT.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-job, immediately force state=IDLE and set rd_en, tree_en, busy, sum_valid and err to 0, rd_addr to 0 and sum_out to 0.
REQ-030 SHALL leave a job aborted by reset without a result; the first start after rst_n deasserts begins a fresh job.

Verification
REQ-031 Bench SHALL cover: len=4, base=0x010, every byte=1 -> reads at 0x010..0x013 in cycles 1..4, tree_en in cycles 2..5, sum_valid in cycle 7, sum_out=32, err=0.
REQ-032 Bench SHALL cover: len=513, all bytes=0xFF -> sum_out=1,046,520, no overflow, sum_valid at cycle 516.
REQ-033 Bench SHALL cover: base=0xFFE, len=3 -> rd_addr sequence 0xFFE, 0xFFF, 0x000.
REQ-034 Bench SHALL cover: len=0 -> sum_valid with sum_out=0, err=0, no rd_en; len=600 -> err=1, no rd_en.
REQ-035 Bench SHALL cover: sum_ready held low for 5 cycles -> sum_out stable, start pulses ignored; next start accepted in the cycle after the handshake, and the second job's sum excludes the first job's sum.
REQ-036 Bench SHALL cover: rst_n pulsed low in mid-READ -> all outputs go to 0 asynchronously, no sum_valid; a following len=2 job returns the correct sum.
